// File: rtl/char_pkg.sv
// Shared types and constants for the characterization stimulus generator.
// Pure declarations: no latency, no flow control.
package char_pkg;

  localparam int          CNT_W     = 16;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_RAND   = 2'd1,
    MODE_WALK   = 2'd2,
    MODE_ZERO   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Right-shifting Galois step: feedback applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_POLY) : (q >> 1);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR, seeded only by reset; steps once per cycle with advance.
// Latency: new value visible the cycle after advance; no backpressure.
module lfsr32
  import char_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/flit_pattern_gen.sv
// Packetized operand-pair generator; first flit one cycle after the accepted start.
// Free-running: no backpressure, start is ignored unless idle, all outputs registered.
module flit_pattern_gen
  import char_pkg::*;
#(
  parameter int          N       = 26,
  parameter int          PAYLOAD = 20,
  parameter int          GAP     = 7,
  parameter int          PACKETS = 10,
  parameter logic [31:0] SEED_A  = 32'hACE1_0001,
  parameter logic [31:0] SEED_B  = 32'h1234_5679
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic             flit_valid,
  output logic [N-1:0]     input1,
  output logic [N-1:0]     input2,
  output logic [CNT_W-1:0] flit_count,
  output logic [CNT_W-1:0] packet_count
);

  localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(PAYLOAD - 1);
  localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] LAST_PKT  = CNT_W'(PACKETS - 1);
  localparam logic [N-1:0]     ONES      = '1;
  localparam logic [N-1:0]     WALK_ONE  = N'(1);
  localparam logic [N-1:0]     WALK_TOP  = N'(64'd1 << (N - 1));

  state_e           state;
  mode_e            mode_q;
  logic [CNT_W-1:0] fidx;
  logic [CNT_W-1:0] gcnt;
  logic [CNT_W-1:0] pidx;
  logic [N-1:0]     walk;
  logic [N-1:0]     walk_nxt;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic [31:0]      qa;
  logic [31:0]      qb;
  logic             advance;

  // Both generators step together, once per emitted random flit.
  assign advance = (state == S_SEND) && (mode_q == MODE_RAND);

  lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .q       (qa)
  );

  lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .q       (qb)
  );

  assign walk_nxt = (walk == WALK_TOP) ? WALK_ONE : (walk << 1);

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (mode_q)
      MODE_TOGGLE: begin
        case (fidx[1:0])
          2'd0:    op_b = ONES;
          2'd1: begin
            op_a = ONES;
            op_b = ONES;
          end
          2'd2:    op_a = ONES;
          default: ;
        endcase
      end
      MODE_RAND: begin
        op_a = qa[N-1:0];
        op_b = qb[N-1:0];
      end
      MODE_WALK: begin
        op_a = walk;
        op_b = ~walk;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mode_q       <= MODE_TOGGLE;
      fidx         <= '0;
      gcnt         <= '0;
      pidx         <= '0;
      walk         <= WALK_ONE;
      busy         <= 1'b0;
      done         <= 1'b0;
      flit_valid   <= 1'b0;
      input1       <= '0;
      input2       <= '0;
      flit_count   <= '0;
      packet_count <= '0;
    end else begin
      done       <= 1'b0;
      flit_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            mode_q       <= mode_e'(mode);
            fidx         <= '0;
            gcnt         <= '0;
            pidx         <= '0;
            walk         <= WALK_ONE;
            flit_count   <= '0;
            packet_count <= '0;
            state        <= S_SEND;
          end
        end
        S_SEND: begin
          busy         <= 1'b1;
          flit_valid   <= 1'b1;
          input1       <= op_a;
          input2       <= op_b;
          flit_count   <= fidx;
          packet_count <= pidx;
          if (fidx == LAST_FLIT) begin
            // Pattern phase restarts with every packet.
            fidx <= '0;
            walk <= WALK_ONE;
            pidx <= pidx + 1'b1;
            if (pidx == LAST_PKT) begin
              state <= S_DONE;
            end else if (GAP != 0) begin
              gcnt  <= '0;
              state <= S_GAP;
            end else begin
              state <= S_SEND;
            end
          end else begin
            fidx <= fidx + 1'b1;
            walk <= walk_nxt;
          end
        end
        S_GAP: begin
          busy         <= 1'b1;
          packet_count <= pidx;
          if (gcnt == LAST_GAP) begin
            state <= S_SEND;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        S_DONE: begin
          busy         <= 1'b0;
          done         <= 1'b1;
          packet_count <= pidx;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
